// File: rtl/dram_slink_cfg_ctrl_pkg.sv
// dram_slink_cfg_ctrl_pkg: register-interface types and default serial-link CTRL values
package dram_slink_cfg_ctrl_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
  localparam logic [31:0] CTRL_ADDR    = 32'h0;
  localparam logic [31:0] ISO_ADDR     = 32'h4;
  localparam logic [31:0] CTRL_RST_VAL = 32'h0000_0301;
  localparam logic [31:0] CTRL_ISO_VAL = 32'h0000_0303;
  localparam logic [31:0] CTRL_RUN_VAL = 32'h0000_0003;
  localparam logic [31:0] ISO_MASK     = 32'h0000_0003;
endpackage

// File: rtl/dram_slink_cfg_ctrl.sv
// dram_slink_cfg_ctrl: DRAM serial-link bring-up sequencer and cfg-port arbiter
module dram_slink_cfg_ctrl #(
  parameter type reg_req_t = dram_slink_cfg_ctrl_pkg::reg_req_t,
  parameter type reg_rsp_t = dram_slink_cfg_ctrl_pkg::reg_rsp_t,
  parameter int unsigned AddrWidth = 32,
  parameter logic [AddrWidth-1:0] CtrlAddr = dram_slink_cfg_ctrl_pkg::CTRL_ADDR,
  parameter logic [AddrWidth-1:0] IsoAddr = dram_slink_cfg_ctrl_pkg::ISO_ADDR,
  parameter logic [31:0] CtrlRstVal = dram_slink_cfg_ctrl_pkg::CTRL_RST_VAL,
  parameter logic [31:0] CtrlIsoVal = dram_slink_cfg_ctrl_pkg::CTRL_ISO_VAL,
  parameter logic [31:0] CtrlRunVal = dram_slink_cfg_ctrl_pkg::CTRL_RUN_VAL,
  parameter logic [31:0] IsoMask = dram_slink_cfg_ctrl_pkg::ISO_MASK,
  parameter int unsigned RstHoldCycles = 16,
  parameter int unsigned PollGap = 8,
  parameter int unsigned MaxPolls = 64,
  parameter logic AutoStart = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     start_i,
  input  reg_req_t sw_req_i,
  output reg_rsp_t sw_rsp_o,
  output reg_req_t cfg_req_o,
  input  reg_rsp_t cfg_rsp_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     err_o
);
  import dram_slink_cfg_ctrl_pkg::*;
  typedef enum logic [3:0] {IDLE, WR_RST, HOLD, WR_REL, WR_RUN, RD_ISO, GAP, DONE, ERR} state_e;
  localparam int unsigned CntMax = RstHoldCycles > PollGap ? RstHoldCycles : PollGap;
  localparam int CW = $clog2(CntMax + 1);
  localparam int PW = $clog2(MaxPolls + 1);
  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0] polls_q, polls_d, polls_inc;
  logic idle, go, ack, iso_clear;
  reg_req_t fsm_req;
  function automatic reg_req_t acc(input logic w, input logic [AddrWidth-1:0] a, input logic [31:0] d);
    acc = '0;
    acc.addr = a;
    acc.write = w;
    acc.wdata = d;
    acc.wstrb = '1;
    acc.valid = 1'b1;
  endfunction
  assign idle = state_q inside {IDLE, DONE, ERR};
  assign ack = cfg_rsp_i.ready;
  assign go = idle && pending_q && (!sw_req_i.valid || cfg_rsp_i.ready);
  assign iso_clear = ((cfg_rsp_i.rdata & IsoMask) == '0) && !cfg_rsp_i.error;
  assign cnt_inc = cnt_q == CW'(CntMax) ? cnt_q : cnt_q + 1'b1;
  assign polls_inc = polls_q == PW'(MaxPolls) ? polls_q : polls_q + 1'b1;
  assign cfg_req_o = idle ? sw_req_i : fsm_req;
  assign sw_rsp_o = idle ? cfg_rsp_i : '0;
  assign busy_o = !idle;
  assign done_o = state_q == DONE;
  assign err_o = state_q == ERR;
  // next state, hold/gap/poll counters and the FSM-owned cfg access
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    polls_d = polls_q;
    fsm_req = '0;
    pending_d = idle && !go && (pending_q || start_i);
    case (state_q)
      WR_RST: begin
        fsm_req = acc(1'b1, CtrlAddr, CtrlRstVal);
        cnt_d = '0;
        if (ack) state_d = cfg_rsp_i.error ? ERR : HOLD;
      end
      HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_q == CW'(RstHoldCycles - 1)) state_d = WR_REL;
      end
      WR_REL: begin
        fsm_req = acc(1'b1, CtrlAddr, CtrlIsoVal);
        if (ack) state_d = cfg_rsp_i.error ? ERR : WR_RUN;
      end
      WR_RUN: begin
        fsm_req = acc(1'b1, CtrlAddr, CtrlRunVal);
        if (ack) state_d = cfg_rsp_i.error ? ERR : RD_ISO;
      end
      RD_ISO: begin
        fsm_req = acc(1'b0, IsoAddr, '0);
        cnt_d = '0;
        if (ack) begin
          polls_d = polls_inc;
          state_d = iso_clear ? DONE : polls_inc == PW'(MaxPolls) ? ERR : PollGap == 0 ? RD_ISO : GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == CW'(PollGap - 1)) state_d = RD_ISO;
      end
      default: begin
        if (go) begin
          state_d = WR_RST;
          polls_d = '0;
        end else if (!idle) state_d = IDLE;
      end
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pending_q <= AutoStart;
      cnt_q <= '0;
      polls_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      cnt_q <= cnt_d;
      polls_q <= polls_d;
    end
  end
endmodule

// File: tb/tb_dram_slink_cfg_ctrl.sv
// tb_dram_slink_cfg_ctrl: table-driven and randomized check of the link bring-up sequencer
module tb_dram_slink_cfg_ctrl;
  import dram_slink_cfg_ctrl_pkg::*;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d; int t;} acc_t;
  typedef struct {int b; logic [31:0] ev; int md; bit bump; int n; bit d; bit e;} vec_t;
  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  reg_req_t sw_req_i = '0, cfg_req_o;
  reg_rsp_t sw_rsp_o, cfg_rsp_i = '0;
  logic busy_o, done_o, err_o;
  int total = 0, bad = 0, cyc = 0;
  int busy_reads = 0, iso_base = 0, iso_reads = 0, max_delay = 0, min_delay = 0, wait_left = 0;
  bit in_acc = 0;
  logic [31:0] err_wdata = '0, ctrl_reg = '0;
  acc_t log_q[$];
  acc_t exp_q[$];
  vec_t tbl[9];
  dram_slink_cfg_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .sw_req_i(sw_req_i), .sw_rsp_o(sw_rsp_o),
    .cfg_req_o(cfg_req_o), .cfg_rsp_i(cfg_rsp_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  // serial-link cfg port model: random ready latency, ISOLATED busy for busy_reads polls
  always @(negedge clk_i) begin
    cfg_rsp_i = '0;
    if (cfg_req_o.valid) begin
      if (!in_acc) begin
        in_acc = 1;
        wait_left = $urandom_range(max_delay, min_delay);
      end
      if (wait_left > 0) wait_left--;
      else begin
        in_acc = 0;
        cfg_rsp_i.ready = 1'b1;
        cfg_rsp_i.error = cfg_req_o.write && err_wdata != 0 && cfg_req_o.wdata == err_wdata;
        if (!cfg_req_o.write) begin
          if (cfg_req_o.addr == ISO_ADDR) begin
            cfg_rsp_i.rdata = (iso_reads - iso_base) < busy_reads ? 32'h3 : 32'h0;
            iso_reads++;
          end else cfg_rsp_i.rdata = ctrl_reg;
        end else if (!cfg_rsp_i.error) ctrl_reg = cfg_req_o.wdata;
        log_q.push_back('{w: cfg_req_o.write, a: cfg_req_o.addr, d: cfg_req_o.wdata, t: cyc});
      end
    end else in_acc = 0;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic chk_req(input string name, input reg_req_t act, input reg_req_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask
  // reference: the access list a bring-up produces for b busy polls and an erroring write value
  task automatic model(input int b, input logic [31:0] ev, output int n, output bit d, output bit e);
    logic [31:0] wv [3];
    wv = '{32'h301, 32'h303, 32'h3};
    exp_q.delete();
    d = 0;
    e = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{w: 1'b1, a: CTRL_ADDR, d: wv[i], t: 0});
      if (wv[i] == ev) begin
        e = 1;
        n = exp_q.size();
        return;
      end
    end
    for (int k = 1; k <= 64; k++) begin
      exp_q.push_back('{w: 1'b0, a: ISO_ADDR, d: 32'h0, t: 0});
      if (k > b) begin
        d = 1;
        n = exp_q.size();
        return;
      end
    end
    e = 1;
    n = exp_q.size();
  endtask
  task automatic do_seq(input string tag, input vec_t v, input bit autostart);
    int base, n, mism, g, gmin, cnt;
    bit d, e, seen;
    reg_req_t pr;
    model(v.b, v.ev, n, d, e);
    busy_reads = v.b;
    iso_base = iso_reads;
    err_wdata = v.ev;
    max_delay = v.md;
    min_delay = 0;
    base = log_q.size();
    if (autostart) rst_ni = 1'b1;
    else pulse_start();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = busy_o;
    end
    chk({tag, ":busy_rise"}, int'(seen), 1);
    chk({tag, ":flags_cleared"}, int'({done_o, err_o}), 0);
    if (v.bump) begin
      repeat (10) tick();
      pulse_start();
    end
    cnt = 0;
    while (busy_o && cnt < 5000) begin
      tick();
      cnt++;
    end
    chk({tag, ":finished"}, int'(busy_o), 0);
    repeat (20) tick();
    chk({tag, ":n_acc"}, log_q.size() - base, v.n);
    chk({tag, ":done"}, int'(done_o), int'(v.d));
    chk({tag, ":err"}, int'(err_o), int'(v.e));
    chk({tag, ":busy_end"}, int'(busy_o), 0);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= log_q.size() || log_q[base+i].w !== exp_q[i].w || log_q[base+i].a !== exp_q[i].a ||
          (exp_q[i].w && log_q[base+i].d !== exp_q[i].d)) mism++;
    chk({tag, ":seq_mismatches"}, mism, 0);
    if (exp_q.size() >= 2 && log_q.size() >= base + 2) begin
      g = log_q[base+1].t - log_q[base].t;
      if (v.md == 0) chk({tag, ":hold_cycles"}, g, 17);
      else chk({tag, ":hold_ge17"}, int'(g >= 17), 1);
    end
    if (exp_q.size() >= 5) begin
      gmin = 1 << 30;
      for (int i = base + 4; i < log_q.size() && i < base + exp_q.size(); i++)
        if (log_q[i].t - log_q[i-1].t < gmin) gmin = log_q[i].t - log_q[i-1].t;
      if (v.md == 0) chk({tag, ":poll_gap"}, gmin, 9);
      else chk({tag, ":poll_gap_ge9"}, int'(gmin >= 9), 1);
    end
    pr = '{addr: $urandom, write: 1'b1, wdata: $urandom, wstrb: 4'ha, valid: 1'b0};
    sw_req_i = pr;
    #1;
    chk_req({tag, ":passthrough"}, cfg_req_o, pr);
    sw_req_i = '0;
  endtask
  initial begin
    int base, mism;
    bit got, stall_ok;
    vec_t v;
    tbl[0] = '{3, 32'h0, 0, 1'b0, 7, 1'b1, 1'b0};
    tbl[1] = '{0, 32'h0, 2, 1'b1, 4, 1'b1, 1'b0};
    tbl[2] = '{1000, 32'h0, 1, 1'b0, 67, 1'b0, 1'b1};
    tbl[3] = '{2, 32'h303, 1, 1'b0, 2, 1'b0, 1'b1};
    tbl[4] = '{5, 32'h3, 0, 1'b0, 3, 1'b0, 1'b1};
    tbl[5] = '{63, 32'h0, 0, 1'b0, 67, 1'b1, 1'b0};
    tbl[6] = '{64, 32'h0, 0, 1'b0, 67, 1'b0, 1'b1};
    tbl[7] = '{0, 32'h301, 0, 1'b0, 1, 1'b0, 1'b1};
    tbl[8] = '{0, 32'h0, 3, 1'b0, 4, 1'b1, 1'b0};
    repeat (3) tick();
    chk("rst:busy", int'(busy_o), 0);
    chk("rst:done", int'(done_o), 0);
    chk("rst:err", int'(err_o), 0);
    chk_req("rst:cfg_req", cfg_req_o, '0);
    chk("rst:sw_ready", int'(sw_rsp_o.ready), 0);
    for (int i = 0; i < 9; i++) do_seq($sformatf("tbl%0d", i), tbl[i], i == 0);
    for (int i = 0; i < 4; i++) begin
      v.b = $urandom_range(70, 0);
      v.ev = $urandom_range(3, 0) == 0 ? 32'h303 : 32'h0;
      v.md = $urandom_range(3, 0);
      v.bump = 0;
      model(v.b, v.ev, v.n, v.d, v.e);
      do_seq($sformatf("rnd%0d", i), v, 1'b0);
    end
    do_seq("to_done", tbl[8], 1'b0);
    err_wdata = '0;
    // sw read in flight when start arrives: it must complete before WR_RST
    busy_reads = 1;
    max_delay = 5;
    min_delay = 5;
    base = log_q.size();
    sw_req_i = '{addr: ISO_ADDR, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    pulse_start();
    got = 0;
    stall_ok = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      #1;
      got = sw_rsp_o.ready;
      if (busy_o) stall_ok = 0;
    end
    chk("swrd:acked", int'(got), 1);
    chk("swrd:no_early_start", int'(stall_ok), 1);
    tick();
    sw_req_i = '0;
    min_delay = 0;
    max_delay = 1;
    iso_base = iso_reads;
    chk("swrd:seq_started", int'(busy_o), 1);
    // sw write issued while busy stalls until the sequence finishes
    sw_req_i = '{addr: CTRL_ADDR, write: 1'b1, wdata: 32'h1, wstrb: 4'hf, valid: 1'b1};
    got = 0;
    stall_ok = 1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk_i);
      #1;
      got = sw_rsp_o.ready;
      if (got && busy_o) stall_ok = 0;
    end
    chk("swwr:acked", int'(got), 1);
    chk("swwr:stalled_while_busy", int'(stall_ok), 1);
    chk("swwr:done_at_ack", int'(done_o), 1);
    tick();
    sw_req_i = '0;
    repeat (5) tick();
    chk("swmix:n_acc", log_q.size() - base, 7);
    mism = 0;
    if (log_q.size() >= base + 7) begin
      if (log_q[base].w !== 1'b0 || log_q[base].a !== ISO_ADDR) mism++;
      if (log_q[base+1].w !== 1'b1 || log_q[base+1].d !== 32'h301) mism++;
      if (log_q[base+6].w !== 1'b1 || log_q[base+6].a !== CTRL_ADDR || log_q[base+6].d !== 32'h1) mism++;
    end else mism = 99;
    chk("swmix:order", mism, 0);
    // in DONE a sw write reaches the link in the same cycle, unmodified
    base = log_q.size();
    sw_req_i = '{addr: CTRL_ADDR, write: 1'b1, wdata: 32'h1, wstrb: 4'hf, valid: 1'b1};
    #1;
    chk_req("done_pt:req", cfg_req_o, sw_req_i);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      #1;
      got = sw_rsp_o.ready;
    end
    chk("done_pt:ready", int'(got), 1);
    chk("done_pt:rsp_err", int'(sw_rsp_o.error), int'(cfg_rsp_i.error));
    tick();
    sw_req_i = '0;
    chk("done_pt:n_acc", log_q.size() - base, 1);
    // reset in the middle of polling, then the AutoStart sequence runs again
    busy_reads = 1000;
    iso_base = iso_reads;
    max_delay = 0;
    base = log_q.size();
    pulse_start();
    for (int i = 0; i < 2000 && log_q.size() - base < 8; i++) tick();
    chk("midrst:polling", int'(log_q.size() - base >= 8), 1);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst:busy", int'(busy_o), 0);
    chk("midrst:done", int'(done_o), 0);
    chk("midrst:err", int'(err_o), 0);
    chk_req("midrst:cfg_req", cfg_req_o, '0);
    repeat (2) tick();
    v = '{2, 32'h0, 0, 1'b0, 6, 1'b1, 1'b0};
    do_seq("midrst_restart", v, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
